mem_arbiter: RTL

- Shares one main-memory port between the core's I-cache read port and its D-cache read and write ports.
- Sits between core and memory. The core's i_*/d_* ports connect directly; the memory's single req/res port connects on the other side.
- Buffers D-cache write-backs, because the core's write port has no back-pressure.
- Allows one outstanding memory transaction and routes each response to its owner.

---
 rtl/mem_arbiter_pkg.sv | 25 ++
 rtl/mem_arb_wq.sv | 62 ++++++
 rtl/mem_arbiter.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared encodings for the memory arbiter: owner tags, FSM states, default queue depth.
// Also supplies defaults for the `WORD_SIZE / `CACHE_LINE_SIZE width macros.
`ifndef WORD_SIZE
`define WORD_SIZE 32
`endif
`ifndef CACHE_LINE_SIZE
`define CACHE_LINE_SIZE 128
`endif

package mem_arbiter_pkg;

  typedef logic [1:0] memarb_owner_t;

  localparam memarb_owner_t MEMARB_OWNER_W = 2'd0;
  localparam memarb_owner_t MEMARB_OWNER_I = 2'd1;
  localparam memarb_owner_t MEMARB_OWNER_D = 2'd2;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_RESP  = 2'd3;

  localparam int MEMARB_WQ_DEPTH = 4;

endpackage

// File: rtl/mem_arb_wq.sv
// Write-back FIFO for the memory arbiter; pointers carry one extra wrap bit
// so full and empty are told apart exactly.
module mem_arb_wq
  import mem_arbiter_pkg::*;
#(
  parameter int DEPTH = MEMARB_WQ_DEPTH,
  parameter int AW    = 32,
  parameter int DW    = 128
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [AW-1:0] push_addr,
  input  logic [DW-1:0] push_data,
  input  logic          pop,
  output logic          full,
  output logic          empty,
  output logic [AW-1:0] head_addr,
  output logic [DW-1:0] head_data
);

  localparam int IW = $clog2(DEPTH);

  logic [IW:0]   wr_ptr_q, wr_ptr_d;
  logic [IW:0]   rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] addr_mem_q [DEPTH];
  logic [DW-1:0] data_mem_q [DEPTH];
  logic          do_push;
  logic          do_pop;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[IW] != rd_ptr_q[IW]) &&
                 (wr_ptr_q[IW-1:0] == rd_ptr_q[IW-1:0]);

  // A push into a full queue is fine when the head leaves in the same cycle.
  assign do_push = push && (!full || pop);
  assign do_pop  = pop && !empty;

  assign wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
  assign rd_ptr_d = do_pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;

  assign head_addr = addr_mem_q[rd_ptr_q[IW-1:0]];
  assign head_data = data_mem_q[rd_ptr_q[IW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      addr_mem_q[wr_ptr_q[IW-1:0]] <= push_addr;
      data_mem_q[wr_ptr_q[IW-1:0]] <= push_data;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one memory port between I-cache reads, D-cache reads and queued D-cache writes.
// Define MEM_ARB_RR_EN for round-robin between I and D reads; default is D over I.
//
// state    | meaning
// ST_IDLE  | pick next owner: queued write first, then reads
// ST_ISSUE | mem_req pulse from the request register
// ST_WAIT  | waiting for mem_res; write ack pops the queue
// ST_RESP  | i_res / d_res pulse to the read owner
`ifndef WORD_SIZE
`define WORD_SIZE 32
`endif
`ifndef CACHE_LINE_SIZE
`define CACHE_LINE_SIZE 128
`endif

module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int WORD_SIZE = `WORD_SIZE,
  parameter int LINE_SIZE = `CACHE_LINE_SIZE,
  parameter int WQ_DEPTH  = MEMARB_WQ_DEPTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_read,
  input  logic [WORD_SIZE-1:0] i_addr,
  output logic                 i_res,
  output logic [LINE_SIZE-1:0] i_res_data,
  output logic [WORD_SIZE-1:0] i_res_addr,
  input  logic                 d_read,
  input  logic [WORD_SIZE-1:0] d_addr,
  output logic                 d_res,
  output logic [LINE_SIZE-1:0] d_res_data,
  output logic [WORD_SIZE-1:0] d_res_addr,
  input  logic                 d_wenable,
  input  logic [WORD_SIZE-1:0] d_w_addr,
  input  logic [LINE_SIZE-1:0] d_w_data,
  output logic                 wq_full,
  output logic                 wq_overflow,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic [WORD_SIZE-1:0] mem_addr,
  output logic [LINE_SIZE-1:0] mem_wdata,
  input  logic                 mem_res,
  input  logic [LINE_SIZE-1:0] mem_res_data,
  input  logic [WORD_SIZE-1:0] mem_res_addr
);

  logic [1:0]           state_q, state_d;
  memarb_owner_t        owner_q, owner_d;
  logic [WORD_SIZE-1:0] req_addr_q, req_addr_d;
  logic [LINE_SIZE-1:0] req_data_q, req_data_d;
  logic [WORD_SIZE-1:0] res_addr_q, res_addr_d;
  logic [LINE_SIZE-1:0] res_data_q, res_data_d;
  logic                 overflow_q, overflow_d;
  logic                 wq_empty;
  logic                 wq_push;
  logic                 wq_pop;
  logic [WORD_SIZE-1:0] wq_head_addr;
  logic [LINE_SIZE-1:0] wq_head_data;
  logic                 pick_d;
`ifdef MEM_ARB_RR_EN
  memarb_owner_t        rr_last_q, rr_last_d;
`endif

  assign wq_push    = d_wenable && !wq_full;
  assign overflow_d = overflow_q || (d_wenable && wq_full);

  mem_arb_wq #(
    .DEPTH (WQ_DEPTH),
    .AW    (WORD_SIZE),
    .DW    (LINE_SIZE)
  ) u_wq (
    .clk       (clk),
    .rst       (rst),
    .push      (wq_push),
    .push_addr (d_w_addr),
    .push_data (d_w_data),
    .pop       (wq_pop),
    .full      (wq_full),
    .empty     (wq_empty),
    .head_addr (wq_head_addr),
    .head_data (wq_head_data)
  );

  always_comb begin
    pick_d = d_read;
`ifdef MEM_ARB_RR_EN
    if (i_read && d_read) pick_d = (rr_last_q == MEMARB_OWNER_I);
`endif
  end

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    req_addr_d = req_addr_q;
    req_data_d = req_data_q;
    res_addr_d = res_addr_q;
    res_data_d = res_data_q;
    wq_pop     = 1'b0;
`ifdef MEM_ARB_RR_EN
    rr_last_d  = rr_last_q;
`endif
    case (state_q)
      ST_IDLE: begin
        // Queued writes go first so a D read never overtakes an older write.
        if (!wq_empty) begin
          owner_d    = MEMARB_OWNER_W;
          req_addr_d = wq_head_addr;
          req_data_d = wq_head_data;
          state_d    = ST_ISSUE;
        end else if (i_read || d_read) begin
          owner_d    = pick_d ? MEMARB_OWNER_D : MEMARB_OWNER_I;
          req_addr_d = pick_d ? d_addr : i_addr;
          req_data_d = '0;
          state_d    = ST_ISSUE;
`ifdef MEM_ARB_RR_EN
          rr_last_d  = pick_d ? MEMARB_OWNER_D : MEMARB_OWNER_I;
`endif
        end
      end
      ST_ISSUE: state_d = ST_WAIT;
      ST_WAIT: begin
        if (mem_res) begin
          res_addr_d = mem_res_addr;
          res_data_d = mem_res_data;
          if (owner_q == MEMARB_OWNER_W) begin
            wq_pop  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            state_d = ST_RESP;
          end
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      owner_q    <= MEMARB_OWNER_W;
      req_addr_q <= '0;
      req_data_q <= '0;
      res_addr_q <= '0;
      res_data_q <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      req_addr_q <= req_addr_d;
      req_data_q <= req_data_d;
      res_addr_q <= res_addr_d;
      res_data_q <= res_data_d;
      overflow_q <= overflow_d;
    end
  end

`ifdef MEM_ARB_RR_EN
  always_ff @(posedge clk) begin
    if (rst) rr_last_q <= MEMARB_OWNER_D;
    else     rr_last_q <= rr_last_d;
  end
`endif

  assign mem_req     = (state_q == ST_ISSUE);
  assign mem_we      = mem_req && (owner_q == MEMARB_OWNER_W);
  assign mem_addr    = req_addr_q;
  assign mem_wdata   = req_data_q;
  assign i_res       = (state_q == ST_RESP) && (owner_q == MEMARB_OWNER_I);
  assign d_res       = (state_q == ST_RESP) && (owner_q == MEMARB_OWNER_D);
  assign i_res_data  = res_data_q;
  assign i_res_addr  = res_addr_q;
  assign d_res_data  = res_data_q;
  assign d_res_addr  = res_addr_q;
  assign wq_overflow = overflow_q;

endmodule
